// File: rtl/spi_link_pkg.sv
// rtl/spi_link_pkg.sv - shared types and constants for the SPI link arbiter
package spi_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LO,
    HI,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_GAP   = 2;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_BIST = 1'b1;

endpackage

// File: rtl/spi_link_shifter.sv
// rtl/spi_link_shifter.sv - transmit/receive shift registers with bit and half-period counters
module spi_link_shifter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-2:0] load_data,
  input  logic              run,
  input  logic              shift,
  input  logic              rx_bit,
  output logic              half_end,
  output logic              last_bit,
  output logic              tx_next_bit,
  output logic [DATA_W-1:0] rx_data
);

  localparam int HW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_cnt;
  // The MSB goes straight to the pad at load time, so only the remaining bits are kept.
  logic [DATA_W-2:0] tx_q;
  logic [DATA_W-1:0] rx_q;

  assign half_end    = (half_cnt == HW'(CLK_DIV - 1));
  assign last_bit    = (bit_cnt == BW'(DATA_W - 1));
  assign tx_next_bit = tx_q[DATA_W-2];
  assign rx_data     = rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (load) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= load_data;
      rx_q     <= '0;
    end else begin
      if (run) begin
        half_cnt <= half_end ? '0 : half_cnt + 1'b1;
      end
      if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
        tx_q    <= tx_q << 1;
        rx_q    <= {rx_q[DATA_W-2:0], rx_bit};
      end
    end
  end

endmodule

// File: rtl/spi_link_arbiter.sv
// rtl/spi_link_arbiter.sv - round-robin SPI master sharing one link between host and BIST
module spi_link_arbiter
  import spi_link_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_GAP   = DEF_CS_GAP
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              miso_s1, miso_s2;
  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] load_data;
  logic              half_end, last_bit, tx_next_bit;
  logic [DATA_W-1:0] rx_data;
  logic              run, shift;
  logic              cs_d, clk_d, mosi_d, rsp_fire;

  always_comb begin
    grant_id = REQ_HOST;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = REQ_BIST;
    end
    accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && (grant_id == REQ_HOST);
    req1_ready = accept && (grant_id == REQ_BIST);
    load_data  = (grant_id == REQ_BIST) ? req1_data : req0_data;
  end

  assign run   = (state_q == LO) || (state_q == HI);
  assign shift = (state_q == HI) && half_end;
  assign busy  = (state_q != IDLE);

  spi_link_shifter #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (nreset),
    .load       (accept),
    .load_data  (load_data[DATA_W-2:0]),
    .run        (run),
    .shift      (shift),
    .rx_bit     (miso_s2),
    .half_end   (half_end),
    .last_bit   (last_bit),
    .tx_next_bit(tx_next_bit),
    .rx_data    (rx_data)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == SETUP) || (state_q == HOLD) || (state_q == GAP)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (cnt_q == 4'(CS_SETUP - 1)) state_d = LO;
      LO:      if (half_end) state_d = HI;
      HI:      if (half_end) state_d = last_bit ? HOLD : LO;
      HOLD:    if (cnt_q == 4'(CS_HOLD - 1)) state_d = GAP;
      GAP:     if (cnt_q == 4'(CS_GAP - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    cs_d     = !((state_d == SETUP) || (state_d == LO) || (state_d == HI) || (state_d == HOLD));
    clk_d    = (state_d == HI);
    rsp_fire = (state_q == HOLD) && (state_d == GAP);
    if (accept) begin
      mosi_d = load_data[DATA_W-1];
    end else if (shift && !last_bit) begin
      mosi_d = tx_next_bit;
    end else if (cs_d) begin
      mosi_d = 1'b0;
    end else begin
      mosi_d = spi_mosi;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      miso_s1      <= 1'b0;
      miso_s2      <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      spi_cs       <= 1'b1;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
    end else begin
      miso_s1  <= spi_miso;
      miso_s2  <= miso_s1;
      spi_cs   <= cs_d;
      spi_clk  <= clk_d;
      spi_mosi <= mosi_d;
      rsp_valid <= rsp_fire;
      if (accept) begin
        last_grant_q <= grant_id;
        owner_q      <= grant_id;
      end
      if (rsp_fire) begin
        rsp_id   <= owner_q;
        rsp_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_link_arbiter.sv
// tb/tb_spi_link_arbiter.sv - directed self-checking bench for spi_link_arbiter
module tb_spi_link_arbiter;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, busy;
  logic [15:0] rsp_data;
  logic        spi_clk, spi_cs, spi_mosi;
  logic        spi_miso = 1'b0;

  spi_link_arbiter dut (
    .clk       (clk),
    .nreset    (nreset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0, fails = 0;

  // Link monitor plus mode-0 slave model returning miso_word MSB first.
  logic [15:0] miso_word = '0;
  logic [15:0] mosi_cap = '0;
  int cs_fall_cyc = 0, cs_rise_cyc = -1000, first_rise = 0, last_rise = 0;
  int rises = 0, bad_period = 0, last_high = 0, min_gap = 1000, rsp_cyc = 0, bidx = 0;
  logic rsp_ids[$];
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && !spi_cs) begin
      cs_fall_cyc = cyc;
      rises = 0;
      bad_period = 0;
      mosi_cap = '0;
      if (cyc - cs_rise_cyc < min_gap) min_gap = cyc - cs_rise_cyc;
      bidx = 15;
      spi_miso = miso_word[bidx];
    end else if (prev_sclk && !spi_clk && !spi_cs && bidx > 0) begin
      bidx = bidx - 1;
      spi_miso = miso_word[bidx];
    end
    if (!prev_sclk && spi_clk) begin
      rises = rises + 1;
      if (rises == 1) first_rise = cyc;
      else if (cyc - last_rise != 8) bad_period = bad_period + 1;
      last_rise = cyc;
      mosi_cap = {mosi_cap[14:0], spi_mosi};
    end
    if (spi_clk) last_high = cyc;
    if (!prev_cs && spi_cs) cs_rise_cyc = cyc;
    if (rsp_valid) begin
      rsp_cyc = cyc;
      rsp_ids.push_back(rsp_id);
    end
    prev_cs = spi_cs;
    prev_sclk = spi_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_rsp(input int target, input string tag);
    for (int k = 0; k < 400 && rsp_ids.size() < target; k++) step();
    chk(tag, 32'(rsp_ids.size() >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && busy; k++) step();
    chk(tag, 32'(busy), 0);
  endtask

  int t0, q0, n;
  logic gid [4];
  int gc [4];
  int both_ready;

  initial begin
    repeat (3) step();
    chk("rst_cs", 32'(spi_cs), 1);
    chk("rst_clk", 32'(spi_clk), 0);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    nreset = 1'b1;
    step();
    chk("idle_no_ready", 32'({req0_ready, req1_ready}), 0);

    // Single host transaction
    miso_word = 16'h3C5A;
    req0_data = 16'hA5C3;
    req0_valid = 1'b1;
    #1;
    chk("t1_ready0", 32'(req0_ready), 1);
    chk("t1_ready1", 32'(req1_ready), 0);
    t0 = cyc;
    q0 = rsp_ids.size();
    step();
    req0_valid = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cs_fall", cs_fall_cyc - t0, 1);
    wait_rsp(q0 + 1, "t1_rsp_seen");
    chk("t1_rsp_lat", rsp_cyc - t0, 133);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_data", 32'(rsp_data), 32'h3C5A);
    chk("t1_mosi", 32'(mosi_cap), 32'hA5C3);
    chk("t1_rises", rises, 16);
    chk("t1_setup", first_rise - cs_fall_cyc, 6);
    chk("t1_period", bad_period, 0);
    chk("t1_hold", cs_rise_cyc - last_high, 3);
    chk("t1_cs_at_c", cs_rise_cyc - rsp_cyc, 0);
    chk("t1_busy_gap", 32'(busy), 1);
    step();
    step();
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t1_pulse", 32'(rsp_valid), 0);
    chk("t1_rsp_hold", 32'(rsp_data), 32'h3C5A);
    chk("t1_mosi_idle", 32'(spi_mosi), 0);

    // Both requesters valid out of reset, held valid: grants alternate
    nreset = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_data = 16'h2222;
    miso_word = 16'h0F0F;
    step();
    step();
    q0 = rsp_ids.size();
    nreset = 1'b1;
    #1;
    n = 0;
    both_ready = 0;
    for (int k = 0; k < 800 && n < 4; k++) begin
      if (req0_ready && req1_ready) both_ready++;
      if (req0_ready || req1_ready) begin
        gid[n] = req1_ready;
        gc[n] = cyc;
        n++;
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t2_grants", n, 4);
    chk("t2_both_ready", both_ready, 0);
    chk("t2_g0", 32'(gid[0]), 0);
    chk("t2_g1", 32'(gid[1]), 1);
    chk("t2_g2", 32'(gid[2]), 0);
    chk("t2_g3", 32'(gid[3]), 1);
    chk("t2_spacing", gc[1] - gc[0], 135);
    wait_rsp(q0 + 4, "t2_rsp_seen");
    chk("t2_id0", 32'(rsp_ids[q0]), 0);
    chk("t2_id1", 32'(rsp_ids[q0 + 1]), 1);
    chk("t2_id2", 32'(rsp_ids[q0 + 2]), 0);
    chk("t2_id3", 32'(rsp_ids[q0 + 3]), 1);
    chk("t2_data", 32'(rsp_data), 32'h0F0F);
    chk("t2_min_gap", 32'(min_gap >= 2), 1);
    wait_idle("t2_idle");

    // Fairness: BIST saturating, host arrives mid-transaction
    q0 = rsp_ids.size();
    req1_valid = 1'b1; req1_data = 16'h3333;
    #1;
    n = 0;
    for (int k = 0; k < 1000 && n < 3; k++) begin
      if (k == 50) req0_valid = 1'b1;
      if (req0_ready || req1_ready) begin
        gid[n] = req1_ready;
        n++;
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t3_grants", n, 3);
    chk("t3_g0", 32'(gid[0]), 1);
    chk("t3_g1", 32'(gid[1]), 0);
    chk("t3_g2", 32'(gid[2]), 1);
    wait_rsp(q0 + 3, "t3_rsp_seen");
    wait_idle("t3_idle");

    // Reset during bit 7
    miso_word = 16'hFFFF;
    req0_data = 16'h1234;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    for (int k = 0; k < 200 && rises < 8; k++) step();
    chk("t4_reached_bit7", 32'(rises >= 8), 1);
    q0 = rsp_ids.size();
    nreset = 1'b0;
    #1;
    chk("t4_cs_async", 32'(spi_cs), 1);
    chk("t4_clk_low", 32'(spi_clk), 0);
    chk("t4_mosi_low", 32'(spi_mosi), 0);
    chk("t4_busy", 32'(busy), 0);
    repeat (3) step();
    nreset = 1'b1;
    step();
    chk("t4_no_rsp", rsp_ids.size() - q0, 0);
    chk("t4_rsp_data_rst", 32'(rsp_data), 0);

    // BIST word after reset, miso all-ones
    req1_data = 16'h00FF;
    req1_valid = 1'b1;
    #1;
    chk("t5_ready1", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    wait_rsp(q0 + 1, "t5_rsp_seen");
    chk("t5_rsp_id", 32'(rsp_id), 1);
    chk("t5_rsp_ones", 32'(rsp_data), 32'hFFFF);
    chk("t5_mosi", 32'(mosi_cap), 32'h00FF);
    wait_idle("t5_idle");

    // Host word, miso all-zeros
    miso_word = 16'h0000;
    req0_data = 16'h8001;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_rsp(q0 + 2, "t6_rsp_seen");
    chk("t6_rsp_id", 32'(rsp_id), 0);
    chk("t6_rsp_zeros", 32'(rsp_data), 32'h0000);
    chk("t6_mosi", 32'(mosi_cap), 32'h8001);
    wait_idle("t6_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
